imm_gen_stage: RTL and testbench

Registered, flow-controlled RISC-V immediate generator for the decode stage. Parametrised for XLEN 32 or 64. Each accepted instruction word is classified by format and its immediate is sign- or zero-extended to XLEN. The result goes into a 2-entry elastic buffer with valid/ready handshakes on both sides, so decode can stall independently of fetch. The block also keeps a saturating count of illegal opcodes for debug.

---
 rtl/imm_gen_stage.sv | 189 ++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decode-stage RISC-V immediate generator.
// Classifies each accepted instruction word by format, extends its immediate
// to XLEN and queues the result in a 2-entry elastic buffer so fetch and
// decode can stall independently. Keeps a saturating illegal-opcode count.
module imm_gen_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } entry_t;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   logic [6:0] opc;
   logic [2:0] funct3;
   entry_t     dec;
   entry_t     head_q, head_d;
   entry_t     tail_q, tail_d;
   logic [1:0] count_q, count_d;
   logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
   logic       push, pop;

   assign opc    = in_instr[6:0];
   assign funct3 = in_instr[14:12];

   // in_ready looks only at the registered occupancy, never at out_ready.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Combinational format classification and immediate extension of in_instr.
   always_comb begin
      dec         = '0;
      dec.instr   = in_instr;
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b1;
      case (opc)
         7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
            dec.fmt     = FMT_I;
            dec.imm     = XLEN'($signed(in_instr[31:20]));
            dec.illegal = 1'b0;
         end
         7'b1110011: begin
            dec.illegal = 1'b0;
            if (funct3[2]) begin
               // CSR immediate forms carry an unsigned 5-bit zimm in the rs1 field.
               dec.fmt = FMT_Z;
               dec.imm = XLEN'(in_instr[19:15]);
            end else begin
               dec.fmt = FMT_I;
               dec.imm = XLEN'($signed(in_instr[31:20]));
            end
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               dec.fmt     = FMT_I;
               dec.imm     = XLEN'($signed(in_instr[31:20]));
               dec.illegal = 1'b0;
            end
         end
         7'b0100011: begin
            dec.fmt     = FMT_S;
            dec.imm     = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            dec.illegal = 1'b0;
         end
         7'b1100011: begin
            dec.fmt     = FMT_B;
            dec.imm     = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                         in_instr[11:8], 1'b0}));
            dec.illegal = 1'b0;
         end
         7'b0110111, 7'b0010111: begin
            dec.fmt     = FMT_U;
            dec.imm     = XLEN'($signed({in_instr[31:12], 12'b0}));
            dec.illegal = 1'b0;
         end
         7'b1101111: begin
            dec.fmt     = FMT_J;
            dec.imm     = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
            dec.illegal = 1'b0;
         end
         7'b0110011: begin
            dec.illegal = 1'b0;
         end
         7'b0111011: begin
            if (XLEN == 64) begin
               dec.illegal = 1'b0;
            end
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   // Buffer next state: head is always the oldest entry, tail only used at count 2.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case (count_q)
         2'd0: begin
            if (push) begin
               head_d  = dec;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = dec;
            end else if (push) begin
               tail_d  = dec;
               count_d = 2'd2;
            end else if (pop) begin
               count_d = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               head_d  = tail_q;
               count_d = 2'd1;
            end
         end
      endcase
   end

   // Illegal-word counter next state, counted on accept only.
   always_comb begin
      ill_cnt_d = ill_cnt_q;
      if (push && dec.illegal) begin
         ill_cnt_d = sat_inc(ill_cnt_q);
      end
   end

   // Control state: occupancy and illegal counter, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 2'd0;
         ill_cnt_q <= '0;
      end else begin
         count_q   <= count_d;
         ill_cnt_q <= ill_cnt_d;
      end
   end

   // Entry storage; contents are don't-care while empty because outputs are masked.
   always_ff @(posedge clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
   end

   assign out_instr   = out_valid ? head_q.instr   : '0;
   assign out_imm     = out_valid ? head_q.imm     : '0;
   assign out_fmt     = out_valid ? head_q.fmt     : FMT_NONE;
   assign out_illegal = out_valid ? head_q.illegal : 1'b0;
   assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one XLEN=32/CNT_W=2 instance and one
// XLEN=64/CNT_W=16 instance share the same input stimulus.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;

   logic        a_in_ready, a_out_valid, a_out_illegal;
   logic [31:0] a_out_instr, a_out_imm;
   logic [2:0]  a_out_fmt;
   logic [1:0]  a_cnt;

   logic        b_in_ready, b_out_valid, b_out_illegal;
   logic [31:0] b_out_instr;
   logic [63:0] b_out_imm;
   logic [2:0]  b_out_fmt;
   logic [15:0] b_cnt;

   int n_run  = 0;
   int n_fail = 0;

   imm_gen_stage #(.XLEN(32), .CNT_W(2)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_instr(a_out_instr), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
      .out_illegal(a_out_illegal), .illegal_cnt(a_cnt)
   );

   imm_gen_stage #(.XLEN(64), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_instr(b_out_instr), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
      .out_illegal(b_out_illegal), .illegal_cnt(b_cnt)
   );

   always #5 clk = ~clk;

   // Directed vectors, expected values worked out by hand from the encodings.
   logic [31:0] words [13] = '{
      32'hFFF00093, 32'hFE000EE3, 32'h800000B7, 32'h3401D073, 32'h00000000,
      32'hFE21AC23, 32'h008000EF, 32'hFFF0809B, 32'h002081B3, 32'h002081BB,
      32'h00000001, 32'h00000073, 32'hFFFFFFFF };
   logic [2:0]  fmt_a [13] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd0, 3'd2, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
   logic [2:0]  fmt_b [13] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd0, 3'd2, 3'd5, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
   logic [31:0] imm_a [13] = '{
      32'hFFFFFFFF, 32'hFFFFFFFC, 32'h80000000, 32'h00000003, 32'h0,
      32'hFFFFFFF8, 32'h00000008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0 };
   logic [63:0] imm_b [13] = '{
      64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h3, 64'h0,
      64'hFFFFFFFFFFFFFFF8, 64'h8, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0 };
   logic        ill_a [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic        ill_b [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [1:0]  cnt_a [13] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
   logic [15:0] cnt_b [13] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [2:0] fa, input logic [31:0] ia, input logic la,
                           input logic [2:0] fb, input logic [63:0] ib, input logic lb);
      chk({tag, " a_valid"}, 64'(a_out_valid), 64'(ev));
      chk({tag, " a_instr"}, 64'(a_out_instr), 64'(ei));
      chk({tag, " a_fmt"},   64'(a_out_fmt),   64'(fa));
      chk({tag, " a_imm"},   64'(a_out_imm),   64'(ia));
      chk({tag, " a_ill"},   64'(a_out_illegal), 64'(la));
      chk({tag, " b_valid"}, 64'(b_out_valid), 64'(ev));
      chk({tag, " b_instr"}, 64'(b_out_instr), 64'(ei));
      chk({tag, " b_fmt"},   64'(b_out_fmt),   64'(fb));
      chk({tag, " b_imm"},   b_out_imm,        ib);
      chk({tag, " b_ill"},   64'(b_out_illegal), 64'(lb));
   endtask

   task automatic chk_ready(input string tag, input logic er);
      chk({tag, " a_in_ready"}, 64'(a_in_ready), 64'(er));
      chk({tag, " b_in_ready"}, 64'(b_in_ready), 64'(er));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with a word offered: it must not be accepted.
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h00000000;
      out_ready = 1'b1;
      tick();
      tick();
      chk_head("reset", 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 3'd0, 64'h0, 1'b0);
      chk_ready("reset", 1'b1);
      chk("reset a_cnt", 64'(a_cnt), 64'd0);
      chk("reset b_cnt", 64'(b_cnt), 64'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("idle a_valid", 64'(a_out_valid), 64'd0);

      // Streaming: push and pop every cycle at count 1; each word heads next cycle.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 13; k++) begin
         in_instr = words[k];
         tick();
         chk_head($sformatf("stream%0d", k), 1'b1, words[k],
                  fmt_a[k], imm_a[k], ill_a[k], fmt_b[k], imm_b[k], ill_b[k]);
         chk_ready($sformatf("stream%0d", k), 1'b1);
         chk($sformatf("stream%0d a_cnt", k), 64'(a_cnt), 64'(cnt_a[k]));
         chk($sformatf("stream%0d b_cnt", k), 64'(b_cnt), 64'(cnt_b[k]));
      end
      in_valid = 1'b0;
      tick();
      chk_head("drained", 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 3'd0, 64'h0, 1'b0);

      // Backpressure: three words offered while the consumer stalls.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093;
      tick();
      chk_ready("bp1", 1'b1);
      chk_head("bp1", 1'b1, 32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      in_instr = 32'h800000B7;
      tick();
      chk_ready("bp2", 1'b0);
      chk_head("bp2", 1'b1, 32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      in_instr = 32'h3401D073;
      tick();
      chk_ready("bp3", 1'b0);
      chk_head("bp3", 1'b1, 32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      // Release: first edge pops only (in_ready was 0), second pushes the 3rd word.
      out_ready = 1'b1;
      tick();
      chk_ready("rel1", 1'b1);
      chk_head("rel1", 1'b1, 32'h800000B7, 3'd4, 32'h80000000, 1'b0, 3'd4, 64'hFFFFFFFF80000000, 1'b0);
      tick();
      chk_head("rel2", 1'b1, 32'h3401D073, 3'd6, 32'h3, 1'b0, 3'd6, 64'h3, 1'b0);
      in_valid = 1'b0;
      tick();
      chk_head("rel3", 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 3'd0, 64'h0, 1'b0);

      // Reset while the buffer holds two entries, with a word still offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFE000EE3;
      tick();
      tick();
      chk_ready("full", 1'b0);
      rst      = 1'b1;
      in_instr = 32'h00000000;
      tick();
      chk_head("midrst", 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 3'd0, 64'h0, 1'b0);
      chk_ready("midrst", 1'b1);
      chk("midrst a_cnt", 64'(a_cnt), 64'd0);
      chk("midrst b_cnt", 64'(b_cnt), 64'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("postrst a_valid", 64'(a_out_valid), 64'd0);
      chk("postrst b_cnt", 64'(b_cnt), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
